// File: rtl/dsp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsp_pkg
// Shared constants and state encoding for the register-file sample streamer.
// Revision: 1.0
// ---------------------------------------------------------------------------
package dsp_pkg;

  localparam int DATA_W = 32;  // sample width, equals register-file word width
  localparam int ADDR_W = 5;   // register index width (32 entries)

  // Streamer control states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage : dsp_pkg
`default_nettype wire

// File: rtl/regfile_sample_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_sample_streamer
// Walks a latched register range through the register file's combinational
// read port and emits each word on a valid/ready stream. One-shot or looped.
// Revision: 1.0
// ---------------------------------------------------------------------------
module regfile_sample_streamer
  import dsp_pkg::*;
#(
  parameter int DATA_W = dsp_pkg::DATA_W,
  parameter int ADDR_W = dsp_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Loop,
  input  logic [ADDR_W-1:0] FirstReg,
  input  logic [ADDR_W-1:0] LastReg,
  output logic [ADDR_W-1:0] ReadReg,
  input  logic [DATA_W-1:0] ReadData,
  output logic [DATA_W-1:0] SampleOut,
  output logic              SampleValid,
  input  logic              SampleReady,
  output logic              SampleLast,
  output logic              Busy,
  output logic              Done
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   read_reg_q, read_reg_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                slast_q, slast_d;
  logic                done_q, done_d;
  logic                loop_q, loop_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic [ADDR_W-1:0]   lastreg_q, lastreg_d;
  logic                handshake;

  assign handshake = valid_q && SampleReady;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath next values; Stop overrides everything once running
  always_comb begin
    state_d    = state_q;
    read_reg_d = read_reg_q;
    sample_d   = sample_q;
    valid_d    = valid_q;
    slast_d    = slast_q;
    done_d     = 1'b0;
    loop_d     = loop_q;
    first_d    = first_q;
    lastreg_d  = lastreg_q;
    unique case (state_q)
      IDLE: begin
        if (Start && !Stop) begin
          first_d    = FirstReg;
          lastreg_d  = LastReg;
          loop_d     = Loop;
          read_reg_d = FirstReg;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (Stop) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          // Read data is captured here only, so later writes to the presented
          // address do not disturb the word on the stream.
          sample_d = ReadData;
          valid_d  = 1'b1;
          slast_d  = (read_reg_q == lastreg_q);
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        if (Stop) begin
          // A coincident handshake is still accepted by the consumer.
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (handshake) begin
          valid_d = 1'b0;
          if (!slast_q) begin
            read_reg_d = read_reg_q + 1'b1;  // wraps 31 -> 0 by width
            state_d    = FETCH;
          end else if (loop_q) begin
            read_reg_d = first_q;
            state_d    = FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and latched-command registers
  always_ff @(posedge clock) begin
    if (reset) begin
      read_reg_q <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      slast_q    <= 1'b0;
      done_q     <= 1'b0;
      loop_q     <= 1'b0;
      first_q    <= '0;
      lastreg_q  <= '0;
    end else begin
      read_reg_q <= read_reg_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      slast_q    <= slast_d;
      done_q     <= done_d;
      loop_q     <= loop_d;
      first_q    <= first_d;
      lastreg_q  <= lastreg_d;
    end
  end

  assign ReadReg     = read_reg_q;
  assign SampleOut   = sample_q;
  assign SampleValid = valid_q;
  assign SampleLast  = slast_q;
  assign Busy        = (state_q != IDLE);
  assign Done        = done_q;

endmodule : regfile_sample_streamer
`default_nettype wire
